// File: rtl/hazard_stall_controller_if.sv
// Bundle between the pipeline datapath and hazard_stall_controller.
// Statistics counters exist only when HAZARD_STATS_EN is defined.
interface hazard_stall_controller_if #(
   parameter int unsigned CNT_W = 16
);

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   logic [4:0] src1;
   logic [4:0] src2;
   logic       two_src;
   logic [4:0] EX_Dest;
   logic       EX_WB_EN;
   logic       EX_MEM_R_EN;
   logic [4:0] MEM_Dest;
   logic       MEM_WB_EN;
   logic       MEM_R_EN;
   logic       MEM_W_EN;
   logic       mem_ready;
   logic       forwarding_enable;
   logic       pc_freeze;
   logic       if_id_freeze;
   logic       id_ex_bubble;
   logic       pipe_freeze;
   logic       mem_busy;
   logic       mem_timeout;
`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] mem_wait_cnt;
`endif

   modport master (
      output src1, src2, two_src, EX_Dest, EX_WB_EN, EX_MEM_R_EN, MEM_Dest, MEM_WB_EN,
             MEM_R_EN, MEM_W_EN, mem_ready, forwarding_enable,
      input  pc_freeze, if_id_freeze, id_ex_bubble, pipe_freeze, mem_busy, mem_timeout
`ifdef HAZARD_STATS_EN
      , input stall_cnt, mem_wait_cnt
`endif
   );

   modport slave (
      input  src1, src2, two_src, EX_Dest, EX_WB_EN, EX_MEM_R_EN, MEM_Dest, MEM_WB_EN,
             MEM_R_EN, MEM_W_EN, mem_ready, forwarding_enable,
      output pc_freeze, if_id_freeze, id_ex_bubble, pipe_freeze, mem_busy, mem_timeout
`ifdef HAZARD_STATS_EN
      , output stall_cnt, mem_wait_cnt
`endif
   );

endinterface

// File: rtl/hazard_stall_controller.sv
// RAW hazard detection plus a data-SRAM wait-state FSM for the five-stage MIPS pipeline.
// Optional saturating stall statistics are enabled by defining HAZARD_STATS_EN.
module hazard_stall_controller #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input logic                      clk,
   input logic                      rst,
   hazard_stall_controller_if.slave bus
);

   if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 15) begin : g_bad_timeout
      $error("MEM_TIMEOUT must be in 1..15");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   typedef enum logic [1:0] {StIdle, StWait, StDone} mem_state_e;

   // Counter holds completed WAIT cycles, so the last allowed one sees MEM_TIMEOUT-1.
   localparam logic [3:0] TimeoutLast = 4'(MEM_TIMEOUT - 1);

   mem_state_e state_q, state_d;
   logic [3:0] tcnt_q, tcnt_d;
   logic       timeout_q, timeout_d;
   logic       hazard;
   logic       mem_req;
   logic       mem_stall;

   function automatic logic match(input logic [4:0] s, input logic [4:0] d);
      return (s == d) && (s != 5'd0);
   endfunction

   always_comb begin
      hazard = 1'b0;
      if (bus.forwarding_enable) begin
         hazard = bus.EX_MEM_R_EN & (match(bus.src1, bus.EX_Dest) |
                                     (bus.two_src & match(bus.src2, bus.EX_Dest)));
      end else begin
         hazard = (bus.EX_WB_EN & (match(bus.src1, bus.EX_Dest) |
                                   (bus.two_src & match(bus.src2, bus.EX_Dest)))) |
                  (bus.MEM_WB_EN & (match(bus.src1, bus.MEM_Dest) |
                                    (bus.two_src & match(bus.src2, bus.MEM_Dest))));
      end
   end

   always_comb begin
      state_d   = state_q;
      tcnt_d    = tcnt_q;
      timeout_d = timeout_q;
      mem_req   = bus.MEM_R_EN | bus.MEM_W_EN;
      unique case (state_q)
         StIdle: begin
            if (mem_req) begin
               state_d = StWait;
               tcnt_d  = 4'd0;
            end
         end
         StWait: begin
            if (bus.mem_ready) begin
               state_d = StDone;
            end else if (tcnt_q == TimeoutLast) begin
               state_d   = StDone;
               timeout_d = 1'b1;
            end else begin
               tcnt_d = tcnt_q + 4'd1;
            end
         end
         // The finished access is still in MEM here; ignore its request.
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      mem_stall = ((state_q == StIdle) & mem_req) | (state_q == StWait);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         tcnt_q    <= 4'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tcnt_q    <= tcnt_d;
         timeout_q <= timeout_d;
      end
   end

   // A memory freeze wins over the bubble so a frozen ID/EX keeps its contents.
   assign bus.pipe_freeze  = ~rst & mem_stall;
   assign bus.pc_freeze    = ~rst & (mem_stall | hazard);
   assign bus.if_id_freeze = ~rst & (mem_stall | hazard);
   assign bus.id_ex_bubble = ~rst & hazard & ~mem_stall;
   assign bus.mem_busy     = ~rst & (state_q == StWait);
   assign bus.mem_timeout  = ~rst & timeout_q;

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] mem_wait_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q    <= '0;
         mem_wait_cnt_q <= '0;
      end else begin
         if (bus.id_ex_bubble && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (mem_stall && (mem_wait_cnt_q != '1)) begin
            mem_wait_cnt_q <= mem_wait_cnt_q + 1'b1;
         end
      end
   end

   assign bus.stall_cnt    = stall_cnt_q;
   assign bus.mem_wait_cnt = mem_wait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: a rule-level model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_hazard_stall_controller;

   localparam int unsigned MEM_TIMEOUT = 15;
   localparam int unsigned CNT_W       = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   hazard_stall_controller_if #(.CNT_W(CNT_W)) bus ();

   hazard_stall_controller #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- model ----------------
   function automatic bit same_reg(input logic [4:0] s, input logic [4:0] d);
      return s == d && s != 5'd0;
   endfunction

   function automatic bit model_hazard();
      bit ex1, ex2, mem1, mem2;
      ex1  = same_reg(bus.src1, bus.EX_Dest);
      ex2  = bus.two_src && same_reg(bus.src2, bus.EX_Dest);
      mem1 = same_reg(bus.src1, bus.MEM_Dest);
      mem2 = bus.two_src && same_reg(bus.src2, bus.MEM_Dest);
      if (bus.forwarding_enable) return bus.EX_MEM_R_EN && (ex1 || ex2);
      return (bus.EX_WB_EN && (ex1 || ex2)) || (bus.MEM_WB_EN && (mem1 || mem2));
   endfunction

   bit      m_waiting = 0;   // an access is outstanding
   bit      m_advance = 0;   // cycle right after an access finished
   int      m_k       = 0;   // index of the current wait cycle, 1-based
   bit      m_to      = 0;
   longint  m_stall   = 0;
   longint  m_memw    = 0;
   longint  sat_max   = (longint'(1) << CNT_W) - 1;

   function automatic bit model_mem_stall();
      bit req;
      req = bus.MEM_R_EN || bus.MEM_W_EN;
      return m_waiting || (!m_advance && req);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_waiting <= 0;
         m_advance <= 0;
         m_k       <= 0;
         m_to      <= 0;
         m_stall   <= 0;
         m_memw    <= 0;
      end else begin
         if (model_hazard() && !model_mem_stall() && m_stall < sat_max) m_stall <= m_stall + 1;
         if (model_mem_stall() && m_memw < sat_max) m_memw <= m_memw + 1;
         if (m_advance) begin
            m_advance <= 0;
         end else if (m_waiting) begin
            if (bus.mem_ready || m_k == MEM_TIMEOUT) begin
               m_waiting <= 0;
               m_advance <= 1;
               if (!bus.mem_ready) m_to <= 1;
            end else begin
               m_k <= m_k + 1;
            end
         end else if (bus.MEM_R_EN || bus.MEM_W_EN) begin
            m_waiting <= 1;
            m_k       <= 1;
         end
      end
   end

   always @(negedge clk) begin
      bit h, ms;
      h  = !rst && model_hazard();
      ms = !rst && model_mem_stall();
      check("pipe_freeze", 32'(bus.pipe_freeze), 32'(ms));
      check("pc_freeze", 32'(bus.pc_freeze), 32'(ms || h));
      check("if_id_freeze", 32'(bus.if_id_freeze), 32'(ms || h));
      check("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(h && !ms));
      check("mem_busy", 32'(bus.mem_busy), 32'(!rst && m_waiting));
      check("mem_timeout", 32'(bus.mem_timeout), 32'(!rst && m_to));
`ifdef HAZARD_STATS_EN
      check("stall_cnt", 32'(bus.stall_cnt), rst ? 32'd0 : 32'(m_stall));
      check("mem_wait_cnt", 32'(bus.mem_wait_cnt), rst ? 32'd0 : 32'(m_memw));
`endif
   end

   // ---------------- directed stimulus ----------------
   task automatic clear_inputs();
      bus.src1 = 5'd0;  bus.src2 = 5'd0;  bus.two_src = 1'b0;
      bus.EX_Dest = 5'd0;  bus.EX_WB_EN = 1'b0;  bus.EX_MEM_R_EN = 1'b0;
      bus.MEM_Dest = 5'd0; bus.MEM_WB_EN = 1'b0;
      bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
      bus.mem_ready = 1'b0; bus.forwarding_enable = 1'b0;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pfb(input string name, input bit pf, input bit pc, input bit bb);
      check({name, ".pipe_freeze"}, 32'(bus.pipe_freeze), 32'(pf));
      check({name, ".pc_freeze"}, 32'(bus.pc_freeze), 32'(pc));
      check({name, ".id_ex_bubble"}, 32'(bus.id_ex_bubble), 32'(bb));
   endtask

   initial begin
      clear_inputs();
      // Inputs that would stall are ignored during reset.
      bus.src1 = 5'd5; bus.EX_Dest = 5'd5; bus.EX_WB_EN = 1'b1; bus.MEM_R_EN = 1'b1;
      @(negedge clk);
      expect_pfb("reset", 0, 0, 0);
      check("reset.mem_busy", 32'(bus.mem_busy), 32'd0);
      check("reset.mem_timeout", 32'(bus.mem_timeout), 32'd0);
      adv();
      clear_inputs();
      rst = 1'b0;

      // Load-use with forwarding: one-cycle bubble.
      bus.forwarding_enable = 1; bus.EX_MEM_R_EN = 1; bus.EX_WB_EN = 1;
      bus.EX_Dest = 5'd5; bus.src1 = 5'd5;
      @(negedge clk);
      expect_pfb("load_use", 0, 1, 1);
      check("load_use.if_id_freeze", 32'(bus.if_id_freeze), 32'd1);
      adv();
      bus.EX_MEM_R_EN = 0; bus.EX_WB_EN = 0; bus.EX_Dest = 5'd0;
      bus.MEM_Dest = 5'd5; bus.MEM_WB_EN = 1;
      @(negedge clk);
      expect_pfb("load_fwd", 0, 0, 0);
      adv();

      // No forwarding: MEM-stage match on src2 gated by two_src.
      clear_inputs();
      bus.MEM_Dest = 5'd3; bus.MEM_WB_EN = 1; bus.src2 = 5'd3; bus.src1 = 5'd7; bus.two_src = 1;
      @(negedge clk);
      expect_pfb("src2_two", 0, 1, 1);
      adv();
      bus.two_src = 0;
      @(negedge clk);
      expect_pfb("src2_one", 0, 0, 0);
      adv();
      clear_inputs();
      bus.EX_Dest = 5'd0; bus.EX_WB_EN = 1; bus.src1 = 5'd0;
      @(negedge clk);
      expect_pfb("r0", 0, 0, 0);
      adv();
      bus.EX_Dest = 5'd9; bus.src1 = 5'd9;
      @(negedge clk);
      expect_pfb("ex_src1", 0, 1, 1);
      adv();

      // Load in MEM, ready on the 3rd wait cycle.
      clear_inputs();
      bus.MEM_R_EN = 1; bus.MEM_WB_EN = 1; bus.MEM_Dest = 5'd6;
      @(negedge clk);
      expect_pfb("ld_req", 1, 1, 0);
      check("ld_req.mem_busy", 32'(bus.mem_busy), 32'd0);
      adv();
      for (int i = 1; i <= 3; i++) begin
         bus.mem_ready = (i == 3);
         @(negedge clk);
         expect_pfb("ld_wait", 1, 1, 0);
         check("ld_wait.mem_busy", 32'(bus.mem_busy), 32'd1);
         adv();
      end
      bus.mem_ready = 0;
      @(negedge clk);
      expect_pfb("ld_done", 0, 0, 0);
      check("ld_done.mem_busy", 32'(bus.mem_busy), 32'd0);
      adv();
      clear_inputs();
      bus.mem_ready = 1;
      @(negedge clk);
      expect_pfb("idle_ready", 0, 0, 0);
      adv();
      bus.mem_ready = 0;
      @(negedge clk);
      check("idle_ready.mem_busy", 32'(bus.mem_busy), 32'd0);
      adv();

      // Back-to-back: load then store with no gap cycle.
      bus.MEM_R_EN = 1;
      @(negedge clk);
      expect_pfb("b2b_req1", 1, 1, 0);
      adv();
      bus.mem_ready = 1;
      @(negedge clk);
      check("b2b_wait1.mem_busy", 32'(bus.mem_busy), 32'd1);
      adv();
      bus.mem_ready = 0;
      @(negedge clk);
      expect_pfb("b2b_done1", 0, 0, 0);
      adv();
      bus.MEM_R_EN = 0; bus.MEM_W_EN = 1;
      @(negedge clk);
      expect_pfb("b2b_req2", 1, 1, 0);
      adv();
      bus.mem_ready = 1;
      @(negedge clk);
      check("b2b_wait2.mem_busy", 32'(bus.mem_busy), 32'd1);
      adv();
      bus.mem_ready = 0;
      @(negedge clk);
      expect_pfb("b2b_done2", 0, 0, 0);
      adv();

      // Load-use in ID while a store waits in MEM.
      clear_inputs();
      bus.forwarding_enable = 1; bus.EX_MEM_R_EN = 1; bus.EX_WB_EN = 1;
      bus.EX_Dest = 5'd4; bus.src1 = 5'd4; bus.MEM_W_EN = 1;
      @(negedge clk);
      expect_pfb("mix_req", 1, 1, 0);
      adv();
      bus.mem_ready = 1;
      @(negedge clk);
      expect_pfb("mix_wait", 1, 1, 0);
      adv();
      bus.mem_ready = 0;
      @(negedge clk);
      expect_pfb("mix_done", 0, 1, 1);
      adv();
      clear_inputs();
      @(negedge clk);
      expect_pfb("mix_after", 0, 0, 0);
      adv();

      // Timeout: ready never arrives.
      bus.MEM_R_EN = 1;
      @(negedge clk);
      expect_pfb("to_req", 1, 1, 0);
      adv();
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         check("to_wait.mem_busy", 32'(bus.mem_busy), 32'd1);
         check("to_wait.mem_timeout", 32'(bus.mem_timeout), 32'd0);
         adv();
      end
      @(negedge clk);
      expect_pfb("to_done", 0, 0, 0);
      check("to_done.mem_busy", 32'(bus.mem_busy), 32'd0);
      check("to_done.mem_timeout", 32'(bus.mem_timeout), 32'd1);
      adv();
      clear_inputs();
      repeat (3) adv();
      @(negedge clk);
      check("to_sticky", 32'(bus.mem_timeout), 32'd1);
      adv();

      // Reset during WAIT aborts the access.
      bus.MEM_R_EN = 1;
      adv();
      @(negedge clk);
      check("rst_wait.mem_busy", 32'(bus.mem_busy), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      expect_pfb("rst_now", 0, 0, 0);
      check("rst_now.mem_busy", 32'(bus.mem_busy), 32'd0);
      check("rst_now.mem_timeout", 32'(bus.mem_timeout), 32'd0);
`ifdef HAZARD_STATS_EN
      check("rst_now.stall_cnt", 32'(bus.stall_cnt), 32'd0);
      check("rst_now.mem_wait_cnt", 32'(bus.mem_wait_cnt), 32'd0);
`endif
      adv();
      rst = 1'b0;
      // Back in IDLE: a held request starts a fresh access.
      @(negedge clk);
      expect_pfb("rst_idle", 1, 1, 0);
      check("rst_idle.mem_busy", 32'(bus.mem_busy), 32'd0);
      check("rst_idle.mem_timeout", 32'(bus.mem_timeout), 32'd0);
      adv();
      bus.mem_ready = 1;
      adv();
      bus.mem_ready = 0;
      adv();
      clear_inputs();
      repeat (2) adv();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
